// File: rtl/dmac_ahbl_regs.sv
// AHB-Lite register slave for the DMA engine: configuration, start pulse,
// done/busy status and a maskable completion interrupt. Zero wait states.
module dmac_ahbl_regs #(
    parameter int OFF_W = 6
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [31:0] saddr,
    output logic [31:0] daddr,
    output logic [2:0]  ssize,
    output logic [2:0]  dsize,
    output logic [2:0]  sinc,
    output logic [2:0]  dinc,
    output logic        wfi,
    output logic [2:0]  irqsrc,
    output logic [7:0]  bsize,
    output logic [7:0]  bcount,
    output logic [31:0] icr_addr,
    output logic [31:0] icr,
    output logic        start,
    input  logic        done,
    input  logic        busy,
    output logic        irq
);

    localparam int AW = OFF_W - 2;
    localparam logic [AW-1:0] A_SADDR  = AW'(0);
    localparam logic [AW-1:0] A_DADDR  = AW'(1);
    localparam logic [AW-1:0] A_CFG    = AW'(2);
    localparam logic [AW-1:0] A_BLK    = AW'(3);
    localparam logic [AW-1:0] A_CTRL   = AW'(4);
    localparam logic [AW-1:0] A_STATUS = AW'(5);
    localparam logic [AW-1:0] A_IE     = AW'(6);
    localparam logic [AW-1:0] A_ICRA   = AW'(7);
    localparam logic [AW-1:0] A_ICR    = AW'(8);
    localparam logic [31:0]   CFG_MASK = 32'h0071_7777;
    localparam logic [31:0]   BLK_MASK = 32'h0000_FFFF;

    logic          valid_q, wr_q;
    logic [AW-1:0] off_q;
    logic [3:0]    strb_q, strb_a;
    logic [31:0]   saddr_q, saddr_d, daddr_q, daddr_d, cfg_q, cfg_d, blk_q, blk_d;
    logic [31:0]   icra_q, icra_d, icr_q, icr_d;
    logic          ie_q, ie_d, flag_q, flag_d, start_q, start_d, irq_q, irq_d;
    logic          acc, we, cfg_we, clr;
    logic [31:0]   wmask, rdata;
    logic          unused_bits;

    assign unused_bits = ^{HADDR[31:OFF_W], HTRANS[0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    assign acc = HSEL & HTRANS[1] & HREADY;

    always_comb begin
        strb_a = 4'b1111;
        case (HSIZE)
            3'd0:    strb_a = 4'b0001 << HADDR[1:0];
            3'd1:    strb_a = HADDR[1] ? 4'b1100 : 4'b0011;
            default: strb_a = 4'b1111;
        endcase
    end

    assign wmask  = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
    assign we     = valid_q & wr_q;
    // Transfer parameters are frozen while the engine is running.
    assign cfg_we = we & ~busy;
    assign clr    = we & (off_q == A_STATUS) & strb_q[0] & HWDATA[1];

    always_comb begin
        saddr_d = saddr_q;
        daddr_d = daddr_q;
        cfg_d   = cfg_q;
        blk_d   = blk_q;
        icra_d  = icra_q;
        icr_d   = icr_q;
        ie_d    = ie_q;
        if (cfg_we) begin
            case (off_q)
                A_SADDR: saddr_d = merge(saddr_q, HWDATA, wmask);
                A_DADDR: daddr_d = merge(daddr_q, HWDATA, wmask);
                A_CFG:   cfg_d   = merge(cfg_q, HWDATA, wmask) & CFG_MASK;
                A_BLK:   blk_d   = merge(blk_q, HWDATA, wmask) & BLK_MASK;
                A_ICRA:  icra_d  = merge(icra_q, HWDATA, wmask);
                A_ICR:   icr_d   = merge(icr_q, HWDATA, wmask);
                default: ;
            endcase
        end
        if (we && off_q == A_IE && strb_q[0])
            ie_d = HWDATA[0];
        start_d = we & (off_q == A_CTRL) & strb_q[0] & HWDATA[0] & ~busy & ~start_q;
        flag_d  = done | (flag_q & ~clr);
        irq_d   = flag_q & ie_q;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            off_q   <= '0;
            strb_q  <= '0;
            saddr_q <= '0;
            daddr_q <= '0;
            cfg_q   <= '0;
            blk_q   <= '0;
            icra_q  <= '0;
            icr_q   <= '0;
            ie_q    <= 1'b0;
            flag_q  <= 1'b0;
            start_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            valid_q <= acc;
            if (acc) begin
                wr_q   <= HWRITE;
                off_q  <= HADDR[OFF_W-1:2];
                strb_q <= strb_a;
            end
            saddr_q <= saddr_d;
            daddr_q <= daddr_d;
            cfg_q   <= cfg_d;
            blk_q   <= blk_d;
            icra_q  <= icra_d;
            icr_q   <= icr_d;
            ie_q    <= ie_d;
            flag_q  <= flag_d;
            start_q <= start_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (off_q)
            A_SADDR:  rdata = saddr_q;
            A_DADDR:  rdata = daddr_q;
            A_CFG:    rdata = cfg_q;
            A_BLK:    rdata = blk_q;
            A_STATUS: rdata = {30'h0, flag_q, busy};
            A_IE:     rdata = {31'h0, ie_q};
            A_ICRA:   rdata = icra_q;
            A_ICR:    rdata = icr_q;
            default:  rdata = 32'h0;
        endcase
    end

    assign HRDATA    = (valid_q & ~wr_q) ? rdata : 32'h0;
    assign HREADYOUT = 1'b1;

    assign saddr    = saddr_q;
    assign daddr    = daddr_q;
    assign ssize    = cfg_q[2:0];
    assign dsize    = cfg_q[6:4];
    assign sinc     = cfg_q[10:8];
    assign dinc     = cfg_q[14:12];
    assign wfi      = cfg_q[16];
    assign irqsrc   = cfg_q[22:20];
    assign bsize    = blk_q[7:0];
    assign bcount   = blk_q[15:8];
    assign icr_addr = icra_q;
    assign icr      = icr_q;
    assign start    = start_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_dmac_ahbl_regs.sv
// Directed bench for dmac_ahbl_regs: one task per feature, inline checks.
module tb_dmac_ahbl_regs;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [31:0] saddr, daddr, icr_addr, icr;
    logic [2:0]  ssize, dsize, sinc, dinc, irqsrc;
    logic        wfi, start, done, busy, irq;
    logic [7:0]  bsize, bcount;

    int passed = 0;
    int total  = 0;

    always #5 HCLK = ~HCLK;

    dmac_ahbl_regs #(.OFF_W(6)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .saddr(saddr), .daddr(daddr),
        .ssize(ssize), .dsize(dsize), .sinc(sinc), .dinc(dinc), .wfi(wfi),
        .irqsrc(irqsrc), .bsize(bsize), .bcount(bcount), .icr_addr(icr_addr),
        .icr(icr), .start(start), .done(done), .busy(busy), .irq(irq)
    );

    task automatic idle_bus();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h0;
    endtask

    // Caller is positioned 1ns after a rising edge; returns 1ns after the
    // edge that ends the data phase.
    task automatic ahb_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HSIZE = sz; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HSIZE = 3'd2; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        idle_bus();
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        HRESET = 1'b1; done = 1'b0; busy = 1'b0; HREADY = 1'b1; HWDATA = 32'h0;
        idle_bus();
        repeat (2) @(posedge HCLK);
        #1;
        total++;
        if ({saddr, daddr, icr_addr, icr, bsize, bcount, ssize, dsize, sinc, dinc,
             irqsrc, wfi, start, irq} !== '0)
            $display("FAIL reset_outputs: some output nonzero saddr=%h cfg=%h,%h,%h,%h start=%b irq=%b",
                     saddr, ssize, dsize, sinc, dinc, start, irq);
        else passed++;
        total++;
        if (HREADYOUT !== 1'b1) $display("FAIL reset_hreadyout: got %b want 1", HREADYOUT);
        else passed++;
        total++;
        if (HRDATA !== 32'h0) $display("FAIL reset_hrdata: got %h want 0", HRDATA);
        else passed++;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        ahb_read(32'h08, r);
        total++;
        if (r !== 32'h0) $display("FAIL reset_cfg_read: got %h want 00000000", r);
        else passed++;
    endtask

    task automatic test_config();
        ahb_write(32'h00, 3'd2, 32'h2000_0000);
        ahb_write(32'h08, 3'd2, 32'h0031_0222);
        ahb_write(32'h04, 3'd2, 32'h3000_0010);
        total++;
        if (saddr !== 32'h2000_0000) $display("FAIL cfg_saddr: got %h want 20000000", saddr);
        else passed++;
        total++;
        if ({ssize, dsize, sinc, dinc, wfi, irqsrc} !== {3'd2, 3'd2, 3'd2, 3'd0, 1'b1, 3'd3})
            $display("FAIL cfg_fields: got ss=%0d ds=%0d si=%0d di=%0d wfi=%b irqs=%0d want 2 2 2 0 1 3",
                     ssize, dsize, sinc, dinc, wfi, irqsrc);
        else passed++;
        total++;
        if (daddr !== 32'h3000_0010) $display("FAIL cfg_daddr: got %h want 30000010", daddr);
        else passed++;
    endtask

    task automatic test_back_to_back();
        // write ICRADDR, then a read of it in the very next address phase
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h1C; HSIZE = 3'd2; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        HWDATA = 32'hCAFE_F00D; HWRITE = 1'b0; HADDR = 32'h1C;
        @(posedge HCLK); #1;
        idle_bus();
        total++;
        if (HRDATA !== 32'hCAFE_F00D) $display("FAIL raw_same_reg: got %h want cafef00d", HRDATA);
        else passed++;
        @(posedge HCLK); #1;
        total++;
        if (icr_addr !== 32'hCAFE_F00D) $display("FAIL icr_addr_out: got %h want cafef00d", icr_addr);
        else passed++;
        // pipelined reads of SADDR then CFG
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        HADDR = 32'h08;
        total++;
        if (HRDATA !== 32'h2000_0000) $display("FAIL b2b_read_saddr: got %h want 20000000", HRDATA);
        else passed++;
        @(posedge HCLK); #1;
        idle_bus();
        total++;
        if (HRDATA !== 32'h0031_0222) $display("FAIL b2b_read_cfg: got %h want 00310222", HRDATA);
        else passed++;
        @(posedge HCLK); #1;
        ahb_write(32'h20, 3'd2, 32'h0000_0004);
        total++;
        if (icr !== 32'h0000_0004) $display("FAIL icr_out: got %h want 00000004", icr);
        else passed++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] r;
        ahb_write(32'h0C, 3'd2, 32'h0000_5A3C);
        total++;
        if ({bcount, bsize} !== 16'h5A3C) $display("FAIL blk_word: got %h%h want 5a3c", bcount, bsize);
        else passed++;
        ahb_write(32'h0D, 3'd0, 32'h0000_AB00);
        total++;
        if ({bcount, bsize} !== 16'hAB3C) $display("FAIL blk_byte: got %h%h want ab3c", bcount, bsize);
        else passed++;
        ahb_read(32'h0C, r);
        total++;
        if (r !== 32'h0000_AB3C) $display("FAIL blk_read: got %h want 0000ab3c", r);
        else passed++;
        ahb_write(32'h02, 3'd1, 32'h1234_0000);
        total++;
        if (saddr !== 32'h1234_0000) $display("FAIL saddr_half: got %h want 12340000", saddr);
        else passed++;
    endtask

    task automatic test_start();
        logic [31:0] r;
        ahb_write(32'h10, 3'd2, 32'h1);
        total++;
        if (start !== 1'b1) $display("FAIL start_pulse: got %b want 1", start);
        else passed++;
        @(posedge HCLK); #1;
        total++;
        if (start !== 1'b0) $display("FAIL start_width: got %b want 0", start);
        else passed++;
        ahb_read(32'h10, r);
        total++;
        if (r !== 32'h0) $display("FAIL ctrl_read: got %h want 0", r);
        else passed++;
        busy = 1'b1;
        ahb_write(32'h10, 3'd2, 32'h1);
        total++;
        if (start !== 1'b0) $display("FAIL start_busy: got %b want 0", start);
        else passed++;
        ahb_write(32'h00, 3'd2, 32'hDEAD_BEEF);
        total++;
        if (saddr !== 32'h1234_0000) $display("FAIL saddr_busy_lock: got %h want 12340000", saddr);
        else passed++;
        ahb_read(32'h14, r);
        total++;
        if (r !== 32'h1) $display("FAIL status_busy: got %h want 00000001", r);
        else passed++;
        busy = 1'b0;
    endtask

    task automatic test_done_irq();
        logic [31:0] r;
        ahb_write(32'h18, 3'd2, 32'h1);
        done = 1'b1;
        @(posedge HCLK); #1;
        done = 1'b0;
        total++;
        if (irq !== 1'b0) $display("FAIL irq_latency: got %b want 0", irq);
        else passed++;
        @(posedge HCLK); #1;
        total++;
        if (irq !== 1'b1) $display("FAIL irq_rise: got %b want 1", irq);
        else passed++;
        ahb_read(32'h14, r);
        total++;
        if (r !== 32'h2) $display("FAIL status_done: got %h want 00000002", r);
        else passed++;
        // clear and set collide in the same edge
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h14; HSIZE = 3'd2; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = 32'h2; done = 1'b1;
        @(posedge HCLK); #1;
        done = 1'b0;
        ahb_read(32'h14, r);
        total++;
        if (r !== 32'h2) $display("FAIL set_wins: got %h want 00000002", r);
        else passed++;
        ahb_write(32'h14, 3'd2, 32'h2);
        @(posedge HCLK); #1;
        total++;
        if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq);
        else passed++;
        ahb_read(32'h14, r);
        total++;
        if (r !== 32'h0) $display("FAIL status_cleared: got %h want 0", r);
        else passed++;
    endtask

    task automatic test_undefined();
        logic [31:0] r;
        ahb_write(32'h3C, 3'd2, 32'hFFFF_FFFF);
        ahb_read(32'h3C, r);
        total++;
        if (r !== 32'h0) $display("FAIL undef_read: got %h want 0", r);
        else passed++;
        ahb_read(32'h08, r);
        total++;
        if (r !== 32'h0031_0222 || saddr !== 32'h1234_0000 || icr !== 32'h4 || {bcount, bsize} !== 16'hAB3C)
            $display("FAIL undef_side_effect: cfg=%h saddr=%h icr=%h blk=%h%h", r, saddr, icr, bcount, bsize);
        else passed++;
        ahb_read(32'h18, r);
        total++;
        if (r !== 32'h1) $display("FAIL ie_read: got %h want 00000001", r);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        done = 1'b1;
        @(posedge HCLK); #1;
        done = 1'b0;
        @(posedge HCLK); #1;
        total++;
        if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b want 1", irq);
        else passed++;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HSIZE = 3'd2; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = 32'h5555_AAAA;
        HRESET = 1'b1;
        #1;
        total++;
        if (irq !== 1'b0 || start !== 1'b0 || saddr !== 32'h0)
            $display("FAIL reset_abort: irq=%b start=%b saddr=%h want 0 0 0", irq, start, saddr);
        else passed++;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        total++;
        if (saddr !== 32'h0) $display("FAIL reset_no_write: got %h want 0", saddr);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_config();
        test_back_to_back();
        test_byte_lanes();
        test_start();
        test_done_irq();
        test_undefined();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmac_ahbl_regs.md
Name: dmac_ahbl_regs

Overview:
AHB-Lite responder that exposes the DMA controller's programming registers to the system bus. It drives the configuration inputs of the DMA bus-master engine (saddr, daddr, sizes, increments, bsize, bcount, wfi, irqsrc, icr_addr, icr) and generates its start pulse. It collects the engine's done/busy into a status register and raises a maskable completion interrupt. It sits on the slave side of the AHB-Lite fabric, opposite the engine's master port.

Parameters:
OFF_W, 6, number of HADDR bits decoded as the register offset (word-aligned; register space is 2^OFF_W bytes).

Ports:
HCLK  in  1  bus clock
HRESET  in  1  asynchronous, active-high reset
HSEL  in  1  slave select
HADDR  in  32  byte address; only [OFF_W-1:0] decoded
HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
HSIZE  in  3  0=byte, 1=half, 2=word
HWRITE  in  1  1=write
HREADY  in  1  bus ready (previous data phase complete)
HWDATA  in  32  write data (data phase)
HREADYOUT  out  1  slave ready; always 1
HRDATA  out  32  read data (data phase)
saddr  out  32  source address
daddr  out  32  destination address
ssize  out  3  source HSIZE
dsize  out  3  destination HSIZE
sinc  out  3  source increment
dinc  out  3  destination increment
wfi  out  1  wait-for-peripheral-IRQ enable
irqsrc  out  3  peripheral IRQ select
bsize  out  8  block size
bcount  out  8  block count
icr_addr  out  32  IRQ-clear register address
icr  out  32  IRQ-clear value
start  out  1  one-cycle start pulse to engine
done  in  1  engine completion pulse
busy  in  1  engine busy level
irq  out  1  completion interrupt

Behaviour:
- Reset (async, HRESET=1): every register, HRDATA source latches, start and irq go to 0; HREADYOUT=1.
- Address phase accepted when HSEL & HTRANS[1] & HREADY. The block latches offset (HADDR[OFF_W-1:2]), HWRITE, and byte-lane strobes from HSIZE/HADDR[1:0]: byte->1 lane, half->2 lanes per HADDR[1], word->4 lanes. Latched valid flag cleared the next cycle unless a new transfer is accepted.
- Zero wait state: write data applied on the rising edge that ends the data phase, per byte lane. Read data is combinational from the latched offset during the data phase. A read immediately following a write to the same register returns the new value.
- Register map (offset: fields):
  0x00 SADDR[31:0]
  0x04 DADDR[31:0]
  0x08 CFG: [2:0] ssize, [6:4] dsize, [10:8] sinc, [14:12] dinc, [16] wfi, [22:20] irqsrc
  0x0C BLK: [7:0] bsize, [15:8] bcount
  0x10 CTRL: [0] start (write-only, reads 0)
  0x14 STATUS: [0] busy (RO, live input), [1] done flag (W1C)
  0x18 IE: [0] irq enable
  0x1C ICRADDR[31:0]
  0x20 ICR[31:0]
- Unused bits read 0. Undefined offsets read 0, and writes to them are ignored.
- Writes to 0x00–0x0C and 0x1C–0x20 while busy=1 are ignored, so the in-flight transfer stays stable.
- start: a data-phase write to CTRL with lane 0 active, HWDATA[0]=1 and busy=0 makes start=1 for exactly the following cycle. It is ignored when busy=1. start is also suppressed if start was already high the previous cycle (no back-to-back pulses).
- done flag: set when done=1. Cleared by a STATUS write with lane 0 active and HWDATA[1]=1. If set and clear occur in the same cycle, set wins.
- irq = done_flag & IE[0], registered. It rises one cycle after the flag or the enable becomes 1.
- Reset asserted mid-transfer aborts the data phase: no register update, and start/irq deassert immediately.

Test Plan:
- Reset: HRESET=1 for 2 cycles -> all outputs 0, HREADYOUT=1. Read 0x08 -> 0x00000000.
- Config write/read: write 0x00=0x20000000, 0x08=0x00310222 (word) -> saddr=0x20000000, ssize=2, dsize=2, sinc=2, dinc=0, wfi=1, irqsrc=3. Back-to-back readback returns the same values.
- Byte lanes: write byte 0xAB to 0x0D (HSIZE=0) -> bcount=0xAB, bsize unchanged. Halfword 0x1234 to 0x02 -> SADDR[31:16]=0x1234.
- Start: busy=0, write CTRL=1 -> start high exactly 1 cycle after the data phase. Repeat with busy=1 -> no pulse, and a SADDR write during busy is ignored.
- Done/irq: IE=1, pulse done -> STATUS=0x2 and irq=1 next cycle. Write STATUS=0x2 while done pulses the same cycle -> flag stays 1. A later clear -> irq=0.
- Undefined access: write 0x3C=0xFFFFFFFF, then read 0x3C -> 0, with no other register changed.
